// File: rtl/screen_sequencer.sv
// Screen controller for the display chain: owns START/PLAY/OVER, drives the one-hot
// overlay enables and commits every screen change on a vsync rising edge.
module screen_sequencer #(
    parameter int OVER_LOCK_FRAMES = 60,
    parameter int LOCK_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    input  logic       vsync_in,
    input  logic       player_dead,
    output logic       start_en,
    output logic       game_en,
    output logic       over_en,
    output logic       game_rst,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_OVER  = 2'd2
    } screen_t;

    localparam logic [LOCK_W-1:0] LOCK_INIT = LOCK_W'(OVER_LOCK_FRAMES);

    screen_t           state_q, state_d;
    logic              b1_q, b2_q, b_prev_q;
    logic              vs_prev_q;
    logic              pending_q, pending_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              start_en_q, start_en_d;
    logic              game_en_q, game_en_d;
    logic              over_en_q, over_en_d;
    logic              game_rst_q, game_rst_d;

    logic press;
    logic frame_start;
    logic commit;
    logic request;

    assign press       = b2_q & ~b_prev_q;
    assign frame_start = vsync_in & ~vs_prev_q;
    // Only the registered request may commit, so a request raised on a frame-start
    // cycle waits for the following frame.
    assign commit      = frame_start & pending_q;

    always_comb begin
        request = 1'b0;
        case (state_q)
            ST_START: request = press;
            ST_PLAY:  request = player_dead;
            ST_OVER:  request = press & (lock_cnt_q == '0);
            default:  request = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        lock_cnt_d = '0;
        game_rst_d = 1'b0;

        if (commit) begin
            pending_d = 1'b0;
        end else if (!pending_q && request) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_START: begin
                if (commit) begin
                    state_d    = ST_PLAY;
                    game_rst_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (commit) begin
                    state_d    = ST_OVER;
                    lock_cnt_d = LOCK_INIT;
                end
            end
            ST_OVER: begin
                if (commit) begin
                    state_d = ST_START;
                end else if (frame_start && lock_cnt_q != '0) begin
                    lock_cnt_d = lock_cnt_q - LOCK_W'(1);
                end else begin
                    lock_cnt_d = lock_cnt_q;
                end
            end
            default: begin
                state_d   = ST_START;
                pending_d = 1'b0;
            end
        endcase

        // Enables follow the next state so they switch on the same edge as state.
        start_en_d = (state_d == ST_START);
        game_en_d  = (state_d == ST_PLAY);
        over_en_d  = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b1_q       <= 1'b0;
            b2_q       <= 1'b0;
            b_prev_q   <= 1'b0;
            vs_prev_q  <= 1'b0;
            state_q    <= ST_START;
            pending_q  <= 1'b0;
            lock_cnt_q <= '0;
            start_en_q <= 1'b1;
            game_en_q  <= 1'b0;
            over_en_q  <= 1'b0;
            game_rst_q <= 1'b0;
        end else begin
            b1_q       <= btn_in;
            b2_q       <= b1_q;
            b_prev_q   <= b2_q;
            vs_prev_q  <= vsync_in;
            state_q    <= state_d;
            pending_q  <= pending_d;
            lock_cnt_q <= lock_cnt_d;
            start_en_q <= start_en_d;
            game_en_q  <= game_en_d;
            over_en_q  <= over_en_d;
            game_rst_q <= game_rst_d;
        end
    end

    assign start_en = start_en_q;
    assign game_en  = game_en_q;
    assign over_en  = over_en_q;
    assign game_rst = game_rst_q;
    assign state    = state_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer: 100-clock frames, vsync high for 4 clocks,
// three-frame game-over lock.
module tb_screen_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_in;
    logic       vsync_in;
    logic       player_dead;
    logic       start_en, game_en, over_en, game_rst;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;
    int fcnt;
    int gr_cnt = 0;

    screen_sequencer #(
        .OVER_LOCK_FRAMES(3),
        .LOCK_W          (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .vsync_in   (vsync_in),
        .player_dead(player_dead),
        .start_en   (start_en),
        .game_en    (game_en),
        .over_en    (over_en),
        .game_rst   (game_rst),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Frame generator: fcnt is the position of the cycle ending at the next edge;
    // fcnt==0 is the frame-start cycle.
    initial begin
        fcnt     = 99;
        vsync_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            fcnt     = (fcnt == 99) ? 0 : fcnt + 1;
            vsync_in = (fcnt < 4);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (game_rst) gr_cnt++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_fcnt(input int n);
        int guard = 0;
        tick();
        while (fcnt != n && guard < 300) begin
            tick();
            guard++;
        end
        if (fcnt != n) check("wait_fcnt_timeout", fcnt, n);
    endtask

    task automatic press_btn();
        btn_in = 1'b1;
        repeat (3) tick();
        btn_in = 1'b0;
        repeat (3) tick();
    endtask

    task automatic check_screen(input string tag, input int s);
        check({tag, "_state"}, int'(state), s);
        check({tag, "_start_en"}, int'(start_en), (s == 0) ? 1 : 0);
        check({tag, "_game_en"}, int'(game_en), (s == 1) ? 1 : 0);
        check({tag, "_over_en"}, int'(over_en), (s == 2) ? 1 : 0);
    endtask

    initial begin
        rst         = 1'b0;
        btn_in      = 1'b0;
        player_dead = 1'b0;
        repeat (3) tick();
        check_screen("in_reset", 0);
        check("in_reset_game_rst", int'(game_rst), 0);
        rst = 1'b1;

        // 1: idle for two frames
        repeat (200) tick();
        check_screen("idle", 0);
        check("idle_game_rst_count", gr_cnt, 0);
        check("idle_pending", int'(dut.pending_q), 0);

        // 2: start game, button held to frame end
        wait_fcnt(30);
        btn_in = 1'b1;
        tick();
        tick();
        check("btn_pending_early", int'(dut.pending_q), 0);
        tick();
        check("btn_pending_set", int'(dut.pending_q), 1);
        wait_fcnt(0);
        check("start_before_commit", int'(state), 0);
        tick();
        check_screen("start_commit", 1);
        check("start_pending_clr", int'(dut.pending_q), 0);
        check("start_game_rst_hi", int'(game_rst), 1);
        tick();
        check("start_game_rst_lo", int'(game_rst), 0);
        wait_fcnt(50);
        check("held_btn_pending", int'(dut.pending_q), 0);
        btn_in = 1'b0;
        check("game_rst_once", gr_cnt, 1);

        // 3: death on the frame-start cycle
        wait_fcnt(0);
        player_dead = 1'b1;
        tick();
        player_dead = 1'b0;
        check("death_no_change", int'(state), 1);
        check("death_pending", int'(dut.pending_q), 1);
        wait_fcnt(0);
        check("death_before_commit", int'(state), 1);
        tick();
        check_screen("death_commit", 2);
        check("death_lock", int'(dut.lock_cnt_q), 3);

        // 4: presses during the lock are ignored
        for (int i = 0; i < 3; i++) begin
            wait_fcnt(30);
            check($sformatf("lock_val_%0d", i), int'(dut.lock_cnt_q), 3 - i);
            press_btn();
            wait_fcnt(50);
            check($sformatf("lock_press_%0d", i), int'(dut.pending_q), 0);
        end
        wait_fcnt(30);
        check("lock_expired", int'(dut.lock_cnt_q), 0);
        press_btn();
        wait_fcnt(50);
        check("unlock_pending", int'(dut.pending_q), 1);
        wait_fcnt(0);
        tick();
        check_screen("over_commit", 0);
        check("over_lock_zero", int'(dut.lock_cnt_q), 0);

        // 5: ignored events and double press
        wait_fcnt(20);
        player_dead = 1'b1;
        tick();
        player_dead = 1'b0;
        tick();
        check("dead_in_start", int'(dut.pending_q), 0);
        wait_fcnt(30);
        press_btn();
        wait_fcnt(40);
        check("dbl_first", int'(dut.pending_q), 1);
        wait_fcnt(50);
        press_btn();
        wait_fcnt(0);
        tick();
        check("dbl_commit", int'(state), 1);
        wait_fcnt(0);
        tick();
        check("dbl_single_step", int'(state), 1);
        wait_fcnt(30);
        press_btn();
        wait_fcnt(50);
        check("press_in_play", int'(dut.pending_q), 0);
        wait_fcnt(0);
        tick();
        check("press_in_play_state", int'(state), 1);
        check("game_rst_twice", gr_cnt, 2);

        // 6: asynchronous reset with a pending request in OVER
        wait_fcnt(30);
        player_dead = 1'b1;
        tick();
        player_dead = 1'b0;
        wait_fcnt(0);
        tick();
        check("rst_setup_over", int'(state), 2);
        repeat (3) wait_fcnt(0);
        wait_fcnt(30);
        press_btn();
        wait_fcnt(45);
        check("rst_setup_pending", int'(dut.pending_q), 1);
        #3;
        rst = 1'b0;
        #1;
        check_screen("async_rst", 0);
        check("async_rst_pending", int'(dut.pending_q), 0);
        tick();
        tick();
        rst = 1'b1;
        wait_fcnt(0);
        tick();
        check_screen("post_rst_frame", 0);
        wait_fcnt(0);
        tick();
        check("post_rst_frame2", int'(state), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
